// File: rtl/router_pkg.sv
// Shared types and constants for the router output buffers.
// Entries carry a header tag alongside each stored byte.
package router_pkg;

  localparam int DATA_W      = 8;
  localparam int DEPTH_DEF   = 16;
  localparam int TIMEOUT_DEF = 30;

  localparam int LEN_MSB  = 7;
  localparam int LEN_LSB  = 2;
  localparam int ADDR_MSB = 1;

  typedef struct packed {
    logic              hdr;
    logic [DATA_W-1:0] data;
  } fifo_entry_t;

  // Packet length counter load: payload bytes plus the parity byte.
  function automatic logic [6:0] pkt_load(
    input logic [DATA_W-1:0] h
  );
    return {1'b0, h[LEN_MSB:LEN_LSB]} + 7'd1;
  endfunction

  function automatic logic [ADDR_MSB:0] pkt_addr(
    input logic [DATA_W-1:0] h
  );
    return h[ADDR_MSB:0];
  endfunction

endpackage

// File: rtl/router_out_fifo_if.sv
// Write/read handshake bundle between the router core,
// one output buffer and its downstream consumer.
interface router_out_fifo_if;

  logic                          write_enb;
  logic                          lfd_state;
  logic [router_pkg::DATA_W-1:0] data_in;
  logic                          read_enb;
  logic [router_pkg::DATA_W-1:0] data_out;
  logic                          v_out;
  logic                          full;
  logic                          empty;
  logic                          rd_last;
  logic                          soft_rst;

  modport master (
    output write_enb,
    output lfd_state,
    output data_in,
    output read_enb,
    input  data_out,
    input  v_out,
    input  full,
    input  empty,
    input  rd_last,
    input  soft_rst
  );

  modport slave (
    input  write_enb,
    input  lfd_state,
    input  data_in,
    input  read_enb,
    output data_out,
    output v_out,
    output full,
    output empty,
    output rd_last,
    output soft_rst
  );

endinterface

// File: rtl/router_fifo_timer.sv
// Unread-data watchdog: requests a flush after TIMEOUT idle
// cycles with data pending and emits a registered pulse.
module router_fifo_timer
  import router_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clock,
  input  logic rst,
  input  logic v_i,
  input  logic rd_i,
  output logic flush_o,
  output logic soft_rst_o
);

  localparam int CLG = $clog2(TIMEOUT);
  localparam int TW  = (CLG > 5) ? CLG : 5;
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] tmr_q;
  logic [TW-1:0] tmr_d;
  logic          soft_q;
  logic          idle;

  assign idle       = v_i && !rd_i;
  assign flush_o    = idle && (tmr_q == LAST);
  assign soft_rst_o = soft_q;

  always_comb begin
    tmr_d = '0;
    if (idle && !flush_o) begin
      tmr_d = tmr_q + TW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      tmr_q  <= '0;
      soft_q <= 1'b0;
    end else begin
      tmr_q  <= tmr_d;
      soft_q <= flush_o;
    end
  end

endmodule

// File: rtl/router_out_fifo.sv
// Per-destination output FIFO of the 1x3 router with header
// tagging, read-side packet tracking and timeout flush.
module router_out_fifo
  import router_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic               clock,
  input  logic               rst,
  router_out_fifo_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  fifo_entry_t       mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW-1:0]     rd_ptr_d;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_d;
  logic [6:0]        pkt_q;
  logic [6:0]        pkt_d;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;
  logic              last_q;
  logic              last_d;
  logic              full;
  logic              empty;
  logic              wr_ok;
  logic              rd_ok;
  logic              flush;
  fifo_entry_t       rd_ent;

  assign full   = (cnt_q == FULL_CNT);
  assign empty  = (cnt_q == '0);
  assign wr_ok  = bus.write_enb && !full && !flush;
  assign rd_ok  = bus.read_enb && !empty;
  assign rd_ent = mem_q[rd_ptr_q];

  assign bus.data_out = data_q;
  assign bus.v_out    = !empty;
  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.rd_last  = last_q;

  router_fifo_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clock      (clock),
    .rst        (rst),
    .v_i        (!empty),
    .rd_i       (bus.read_enb),
    .flush_o    (flush),
    .soft_rst_o (bus.soft_rst)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    pkt_d    = pkt_q;
    data_d   = data_q;
    last_d   = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      pkt_d    = '0;
      data_d   = '0;
    end else begin
      if (wr_ok) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (rd_ok) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        data_d   = rd_ent.data;
        if (rd_ent.hdr) begin
          pkt_d = pkt_load(rd_ent.data);
        end else if (pkt_q != '0) begin
          pkt_d  = pkt_q - 7'd1;
          last_d = (pkt_q == 7'd1);
        end
      end
      case ({wr_ok, rd_ok})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      pkt_q    <= '0;
      data_q   <= '0;
      last_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      pkt_q    <= pkt_d;
      data_q   <= data_d;
      last_q   <= last_d;
    end
  end

  // Storage needs no reset: pointers and occupancy gate every read.
  always_ff @(posedge clock) begin
    if (!rst && wr_ok) begin
      mem_q[wr_ptr_q] <= '{hdr: bus.lfd_state, data: bus.data_in};
    end
  end

endmodule

// File: tb/tb_router_out_fifo.sv
// Directed plus randomized bench for router_out_fifo against a
// queue-based reference model.
module tb_router_out_fifo;
  import router_pkg::*;

  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 30;

  logic clk = 1'b0;
  logic rst = 1'b1;

  router_out_fifo_if bus ();

  router_out_fifo #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clock (clk),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [8:0] q[$];
  int         rem  = 0;
  int         idle = 0;
  logic [7:0] e_data = 8'h00;
  logic       e_last = 1'b0;
  logic       e_soft = 1'b0;
  int         soft_seen = 0;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("data_out", bus.data_out, e_data);
    chk("v_out", 8'(bus.v_out), 8'(q.size() != 0));
    chk("full", 8'(bus.full), 8'(q.size() == DEPTH));
    chk("empty", 8'(bus.empty), 8'(q.size() == 0));
    chk("rd_last", 8'(bus.rd_last), 8'(e_last));
    chk("soft_rst", 8'(bus.soft_rst), 8'(e_soft));
    if (bus.soft_rst === 1'b1) soft_seen++;
  endtask

  // Reference: occupancy is the queue, packet end counted in bytes.
  task automatic model(input logic we, input logic lfd,
                       input logic [7:0] din, input logic re,
                       input logic r);
    int         n;
    logic       fl;
    logic [8:0] ent;
    n = q.size();
    if (r) begin
      q.delete();
      rem = 0; idle = 0;
      e_data = 8'h00; e_last = 1'b0; e_soft = 1'b0;
    end else begin
      fl = (n > 0) && !re && (idle == TIMEOUT - 1);
      e_last = 1'b0;
      e_soft = fl;
      if (fl) begin
        q.delete();
        rem = 0; idle = 0;
        e_data = 8'h00;
      end else begin
        if (re && n > 0) begin
          ent = q.pop_front();
          e_data = ent[7:0];
          if (ent[8]) rem = int'(ent[7:2]) + 1;
          else if (rem > 0) begin
            rem--;
            e_last = (rem == 0);
          end
        end
        if (we && n < DEPTH) q.push_back({lfd, din});
        idle = (re || n == 0) ? 0 : idle + 1;
      end
    end
  endtask

  task automatic step(input logic we, input logic lfd,
                      input logic [7:0] din, input logic re,
                      input logic r);
    bus.write_enb = we;
    bus.lfd_state = lfd;
    bus.data_in   = din;
    bus.read_enb  = re;
    rst           = r;
    model(we, lfd, din, re, r);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic read_n(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  int         wpos = 0;
  int         wlen = 0;
  logic [7:0] wpar = 8'h00;
  int         burst = 0;

  initial begin
    logic       we;
    logic       re;
    logic       lfd;
    logic [7:0] b;
    int         s0;

    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    idle_n(1);

    // Single packet: header L=3, three payload bytes, parity.
    step(1'b1, 1'b1, 8'h0D, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h22, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h33, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'hA5, 1'b0, 1'b0);
    read_n(5);
    idle_n(1);

    // Fill to full, overflow write, drain in order.
    for (int i = 1; i <= 16; i++) step(1'b1, 1'b0, 8'(i), 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h99, 1'b0, 1'b0);
    read_n(16);

    // Full plus simultaneous read/write: the write is dropped.
    for (int i = 1; i <= 16; i++) step(1'b1, 1'b0, 8'(i), 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h77, 1'b1, 1'b0);
    read_n(15);
    idle_n(1);

    // Timeout flush after TIMEOUT unread cycles.
    s0 = soft_seen;
    step(1'b1, 1'b0, 8'h5A, 1'b0, 1'b0);
    idle_n(32);
    chk("soft_pulses", 8'(soft_seen - s0), 8'd1);

    // One read before expiry restarts the timeout count.
    s0 = soft_seen;
    step(1'b1, 1'b0, 8'hC1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'hC2, 1'b0, 1'b0);
    idle_n(27);
    read_n(1);
    idle_n(29);
    chk("no_early_flush", 8'(soft_seen - s0), 8'd0);
    idle_n(3);
    chk("late_flush", 8'(soft_seen - s0), 8'd1);

    // Reset mid-packet while reading.
    step(1'b1, 1'b1, 8'h09, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h44, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h55, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h66, 1'b0, 1'b0);
    read_n(2);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    read_n(3);
    idle_n(2);

    // Randomized packet traffic with idle bursts and rare resets.
    for (int c = 0; c < 1500; c++) begin
      we = ($urandom_range(0, 99) < 55);
      if (burst > 0) begin
        re = 1'b0;
        burst--;
      end else begin
        re = ($urandom_range(0, 99) < 50);
        if ($urandom_range(0, 99) < 2) burst = $urandom_range(20, 40);
      end
      lfd = 1'b0;
      b = 8'($urandom);
      if (we) begin
        if (wpos == 0) begin
          wlen = $urandom_range(0, 5);
          b = {6'(wlen), 2'($urandom_range(0, 2))};
          lfd = 1'b1;
          wpar = b;
          wpos = 1;
        end else if (wpos <= wlen) begin
          wpar ^= b;
          wpos++;
        end else begin
          b = wpar;
          wpos = 0;
        end
      end
      step(we, lfd, b, re, ($urandom_range(0, 499) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
